decoder_scan_n: RTL and testbench
=================================

// Module: decoder_scan_n
//
// PURPOSE
//   Parametrised N-to-2^N one-hot decoder with registered outputs and an
//   auto-scan mode. In direct mode it decodes a select input, one cycle late.
//   In scan mode it steps through every output line in turn, holding each
//   line for DWELL_CYCLES cycles. It drives the row/column selects of the
//   game-of-life LED matrix and is the sequential successor to the fixed
//   2-to-4 decoder.
//
// PARAMETERS
//   N             3   select width; out is 2**N bits wide (N >= 1)
//   DWELL_CYCLES  4   cycles each line stays active in scan mode (>= 1)
//
// PORTS
//   clk    input   1        system clock; all state changes on rising edge
//   rst    input   1        synchronous, active-high reset
//   ena    input   1        global enable; low forces out to all-zero
//   mode   input   1        0 = direct decode, 1 = auto-scan
//   in     input   N        select value, used in direct mode only
//   out    output  2**N     one-hot (or zero) decoded lines, from flops
//   index  output  N        currently selected line number
//   wrap   output  1        one-cycle pulse when scan index wraps to 0
//
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge):
//     - index=0, dwell counter=0, wrap=0, internal enable flag=0, so out=0.
//     - Reset overrides every other input, including in mid-scan.
//   - All outputs come from flops: out = ena_q ? (1 << index) : 0.
//     - ena_q is ena registered each cycle.
//     - Enable takes effect with 1-cycle latency in both modes.
//   - Direct mode (mode=0):
//     - Each edge: index <= in, dwell counter <= 0, wrap <= 0.
//     - Latency in -> out is exactly 1 cycle. Same behaviour as the
//       combinational decoder, but registered.
//   - Scan mode (mode=1, ena=1):
//     - Dwell counter counts 0..DWELL_CYCLES-1.
//     - When the counter is at DWELL_CYCLES-1: counter <= 0 and
//       index <= index+1 (mod 2**N).
//     - wrap <= 1 on the edge where index goes from 2**N-1 to 0;
//       otherwise wrap <= 0.
//     - Each line is therefore active for exactly DWELL_CYCLES cycles.
//       A full frame is 2**N * DWELL_CYCLES cycles.
//     - DWELL_CYCLES=1: index advances every cycle and the counter stays 0.
//   - Scan mode, ena=0:
//     - index and dwell counter hold; wrap <= 0; out goes 0 after 1 cycle.
//     - When ena returns, scanning resumes from the held index and count.
//   - Mode changes:
//     - Direct -> scan: scanning starts from the index last loaded from in,
//       with the counter at 0.
//     - Scan -> direct: the counter clears and index loads from in on that
//       same edge.
//   - Arithmetic:
//     - index is an unsigned N-bit value that wraps naturally.
//     - The dwell counter is $clog2(DWELL_CYCLES)+1 bits wide and never
//       exceeds DWELL_CYCLES-1.
//   - Invariants:
//     - out is never multi-hot.
//     - out==0 whenever ena_q==0.
//     - wrap is never high for two consecutive cycles, except when
//       N... (n/a: with N>=1 and DWELL>=1, wrap is high at most once per
//       frame).
//
// TESTING
//   1. Reset then hold: N=3, rst=1 for 2 cycles, then ena=0
//      -> out=8'h00, index=0, wrap=0 on every cycle.
//   2. Direct sweep: mode=0, ena=1, in=0..7, one value per cycle
//      -> out one cycle later = 01,02,04,...,80 and index=in (delayed).
//   3. Scan frame: mode=1, ena=1, DWELL=4, 40 cycles
//      -> each one-hot value is held 4 cycles; 01 -> 80 -> 01;
//      -> wrap=1 for exactly one cycle, aligned with index returning to 0,
//         at cycle 32 after the start.
//   4. Pause: in scan, drop ena for 5 cycles at index=5, count=2
//      -> out=0 during the pause;
//      -> on resume, index=5 stays active for 1 more cycle, then moves to 6.
//   5. Mode switch and reset: mid-scan at index=3, set mode=0 with in=6
//      -> next cycle out=8'h40. Then assert rst during scan
//      -> next cycle out=0, index=0, wrap=0.
//   6. Edge parameters: N=1 with DWELL=1 -> out toggles 01,10 every cycle
//      and wrap pulses every 2 cycles.

Source files
------------

// File: rtl/decoder_scan_n.sv
// N-to-2^N one-hot decoder with registered lines and an auto-scan mode that
// steps through every line, holding each for DWELL_CYCLES cycles.

module decoder_scan_n_line #(
  parameter int N    = 3,
  parameter int LINE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] sel,
  output logic         line_q
);
  localparam logic [N-1:0] MATCH = N'(LINE);

  // Each line flop captures the enable together with the next index, so the
  // line already reflects ena_q and index without an extra stage.
  always_ff @(posedge clk) begin
    if (rst) line_q <= 1'b0;
    else     line_q <= ena && (sel == MATCH);
  end
endmodule

module decoder_scan_n #(
  parameter int N            = 3,
  parameter int DWELL_CYCLES = 4,
  localparam int LINES       = 2**N,
  localparam int CW          = $clog2(DWELL_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             mode,
  input  logic [N-1:0]     in,
  output logic [LINES-1:0] out,
  output logic [N-1:0]     index,
  output logic             wrap
);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DWELL_CYCLES - 1);
  localparam logic [N-1:0]  LAST_LINE = N'(LINES - 1);

  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0]  index_d;
  logic          wrap_d;

  always_comb begin
    index_d = index;
    cnt_d   = cnt;
    wrap_d  = 1'b0;
    if (!mode) begin
      index_d = in;
      cnt_d   = '0;
    end else if (ena) begin
      if (cnt == LAST_CNT) begin
        cnt_d   = '0;
        index_d = index + N'(1);
        wrap_d  = (index == LAST_LINE);
      end else begin
        cnt_d   = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      index <= index_d;
      cnt   <= cnt_d;
      wrap  <= wrap_d;
    end
  end

  for (genvar g = 0; g < LINES; g++) begin : g_line
    decoder_scan_n_line #(.N(N), .LINE(g)) u_line (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .sel    (index_d),
      .line_q (out[g])
    );
  end
endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: directed scenarios plus random traffic against a
// frame-position model, on an N=3/DWELL=4 and an N=1/DWELL=1 instance.

module tb_decoder_scan_n;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, ena_a = 1'b0, mode_a = 1'b0;
  logic [2:0] in_a = '0, idx_a;
  logic [7:0] out_a;
  logic       wrap_a;

  logic       rst_b = 1'b1, ena_b = 1'b0, mode_b = 1'b0;
  logic [0:0] in_b = '0, idx_b;
  logic [1:0] out_b;
  logic       wrap_b;

  decoder_scan_n #(.N(3), .DWELL_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst_a), .ena(ena_a), .mode(mode_a), .in(in_a),
    .out(out_a), .index(idx_a), .wrap(wrap_a));

  decoder_scan_n #(.N(1), .DWELL_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .ena(ena_b), .mode(mode_b), .in(in_b),
    .out(out_b), .index(idx_b), .wrap(wrap_b));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: position within the frame, pos = line*DWELL + count.
  int pos_a = 0, enq_a = 0, wr_a = 0;
  int pos_b = 0, enq_b = 0, wr_b = 0;

  task automatic cyc_a(input bit r, input bit e, input bit m, input int i);
    rst_a = r; ena_a = e; mode_a = m; in_a = 3'(i);
    @(posedge clk);
    if (r) begin
      pos_a = 0; enq_a = 0; wr_a = 0;
    end else begin
      enq_a = e;
      if (!m) begin
        pos_a = (i % 8) * 4; wr_a = 0;
      end else if (e) begin
        pos_a = (pos_a + 1) % 32; wr_a = (pos_a == 0);
      end else wr_a = 0;
    end
    #1;
    chk("a_out",  out_a,  enq_a ? (1 << (pos_a / 4)) : 0);
    chk("a_idx",  idx_a,  pos_a / 4);
    chk("a_wrap", wrap_a, wr_a);
  endtask

  task automatic cyc_b(input bit r, input bit e, input bit m, input int i);
    rst_b = r; ena_b = e; mode_b = m; in_b = 1'(i);
    @(posedge clk);
    if (r) begin
      pos_b = 0; enq_b = 0; wr_b = 0;
    end else begin
      enq_b = e;
      if (!m) begin
        pos_b = i % 2; wr_b = 0;
      end else if (e) begin
        pos_b = (pos_b + 1) % 2; wr_b = (pos_b == 0);
      end else wr_b = 0;
    end
    #1;
    chk("b_out",  out_b,  enq_b ? (1 << pos_b) : 0);
    chk("b_idx",  idx_b,  pos_b);
    chk("b_wrap", wrap_b, wr_b);
  endtask

  initial begin
    int nw, wc;
    bit m;

    // reset then hold disabled
    cyc_a(1, 0, 0, 0); cyc_a(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc_a(0, 0, 0, 0);

    // direct sweep
    for (int k = 0; k < 8; k++) cyc_a(0, 1, 0, k);
    chk("sweep_last", out_a, 8'h80);

    // one full scan frame plus a bit
    cyc_a(1, 1, 1, 0);
    nw = 0; wc = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc_a(0, 1, 1, $urandom_range(7));
      if (wrap_a) begin nw++; wc = k; end
    end
    chk("scan_wraps", nw, 1);
    chk("wrap_cycle", wc, 32);

    // pause at index 5, count 2
    cyc_a(1, 1, 1, 0);
    for (int k = 0; k < 22; k++) cyc_a(0, 1, 1, 0);
    for (int k = 0; k < 5; k++) cyc_a(0, 0, 1, $urandom_range(7));
    chk("pause_out", out_a, 8'h00);
    cyc_a(0, 1, 1, 0);
    chk("resume_hold", out_a, 8'h20);
    cyc_a(0, 1, 1, 0);
    chk("resume_next", out_a, 8'h40);

    // mode switch mid-scan, then reset mid-scan
    cyc_a(1, 1, 1, 0);
    for (int k = 0; k < 12; k++) cyc_a(0, 1, 1, 0);
    chk("at_idx3", idx_a, 3);
    cyc_a(0, 1, 0, 6);
    chk("switch_out", out_a, 8'h40);
    for (int k = 0; k < 5; k++) cyc_a(0, 1, 1, 0);
    cyc_a(1, 1, 1, 0);
    chk("rst_out", out_a, 8'h00);

    // random traffic
    m = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(9) == 0) m = ~m;
      cyc_a($urandom_range(49) == 0, $urandom_range(4) != 0, m, $urandom_range(7));
    end

    // N=1, DWELL=1: toggles every cycle, wrap every 2
    cyc_b(1, 0, 0, 0);
    nw = 0;
    for (int k = 0; k < 8; k++) begin
      cyc_b(0, 1, 1, 0);
      if (wrap_b) nw++;
    end
    chk("b_wraps", nw, 4);
    m = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(7) == 0) m = ~m;
      cyc_b($urandom_range(39) == 0, $urandom_range(4) != 0, m, $urandom_range(1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
